// File: rtl/fifo_rd_stream.sv
// FIFO read side to valid/ready stream adapter with a 2-entry skid buffer.
// Optional `define FIFO_RD_STREAM_CNT_EN adds o_word_cnt, a 32-bit transfer counter.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic [DATA_WIDTH-1:0] o_m_data
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [31:0]           o_word_cnt
`endif
);

    logic [DATA_WIDTH-1:0] buf_q [0:1];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            cnt;
    logic                  inf;
    logic [1:0]            occ;
    logic                  xfer;

    assign occ       = cnt + {1'b0, inf};
    assign xfer      = o_m_valid && i_m_ready;
    assign o_m_valid = (cnt != 2'd0);
    assign o_m_data  = buf_q[rd_ptr];

    // Reserved slots (buffered + in flight) never exceed two; a pop is only
    // issued into a free slot or one being vacated by a transfer this edge.
    // NOTE: the pop is gated by reset directly, since the cleared state alone
    // would still request a word from a non-empty FIFO during reset.
    assign o_fifo_rd_en = !i_rst && !i_fifo_empty && ((occ < 2'd2) || xfer);

    // NOTE: the two buffer words are reset so o_m_data reads zero in reset;
    // this is cheap at this depth and keeps the output deterministic.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            cnt      <= 2'd0;
            inf      <= 1'b0;
        end else begin
            inf <= o_fifo_rd_en;
            if (inf) begin
                buf_q[wr_ptr] <= i_fifo_rd_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (xfer) begin
                rd_ptr <= ~rd_ptr;
            end
            // Capture with simultaneous transfer leaves the count unchanged;
            // the new word lands behind the remaining entry via wr_ptr.
            case ({inf, xfer})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef FIFO_RD_STREAM_CNT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_word_cnt <= 32'd0;
        end else if (xfer) begin
            o_word_cnt <= o_word_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: array-backed FIFO model, reset table,
// directed corner sequences and a randomized run against an in-order scoreboard.
module tb_fifo_rd_stream;

    localparam int DW    = 64;
    localparam int DEPTH = 4096;

    logic          i_clk;
    logic          i_rst;
    logic          i_fifo_empty;
    logic          o_fifo_rd_en;
    logic [DW-1:0] i_fifo_rd_data;
    logic          o_m_valid;
    logic          i_m_ready;
    logic [DW-1:0] o_m_data;
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [31:0]   o_word_cnt;
    logic [31:0]   cnt_model;
`endif

    fifo_rd_stream #(.DATA_WIDTH(DW)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_fifo_empty   (i_fifo_empty),
        .o_fifo_rd_en   (o_fifo_rd_en),
        .i_fifo_rd_data (i_fifo_rd_data),
        .o_m_valid      (o_m_valid),
        .i_m_ready      (i_m_ready),
        .o_m_data       (o_m_data)
`ifdef FIFO_RD_STREAM_CNT_EN
        ,
        .o_word_cnt     (o_word_cnt)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // FIFO model: words written at wr_idx by the stimulus, popped at rd_idx.
    logic [DW-1:0] fmem [0:DEPTH-1];
    int wr_idx = 0;
    int rd_idx = 0;
    assign i_fifo_empty = (rd_idx == wr_idx);

    always @(posedge i_clk) begin
        if (o_fifo_rd_en && (rd_idx < wr_idx)) begin
            i_fifo_rd_data <= fmem[rd_idx];
            rd_idx         <= rd_idx + 1;
        end
    end

    int n_vec = 0;
    int n_bad = 0;
    int xfer_idx = 0;
    logic          s_v, s_re, p_hold;
    logic [DW-1:0] s_d, p_d;

    typedef struct {
        logic          rst;
        logic          exp_re;
        logic          exp_v;
        logic [DW-1:0] exp_d;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        if (wr_idx < DEPTH) begin
            fmem[wr_idx] = w;
            wr_idx++;
        end
    endtask

    task automatic set_reset(input logic r);
        i_rst  = r;
        p_hold = 1'b0;
        if (r) begin
            xfer_idx = rd_idx;
`ifdef FIFO_RD_STREAM_CNT_EN
            cnt_model = 32'd0;
`endif
        end
    endtask

    // One cycle: drive ready at the falling edge, sample 1 ns later, check
    // the rules the next rising edge will act on, then advance.
    task automatic step(input logic rdy);
        i_m_ready = rdy;
        #1;
        s_v  = o_m_valid;
        s_re = o_fifo_rd_en;
        s_d  = o_m_data;
        if (s_re) check("no_underflow_pop", {63'd0, i_fifo_empty || i_rst}, 64'd0);
        check("outstanding_le_2", {63'd0, (rd_idx - xfer_idx) <= 2}, 64'd1);
        if (p_hold && !i_rst) begin
            check("hold_valid", {63'd0, s_v}, 64'd1);
            check("hold_data", s_d, p_d);
        end
`ifdef FIFO_RD_STREAM_CNT_EN
        check("word_cnt", {32'd0, o_word_cnt}, {32'd0, cnt_model});
`endif
        if (s_v && rdy && !i_rst) begin
            check("popped_before_sent", {63'd0, xfer_idx < rd_idx}, 64'd1);
            check("stream_order", s_d, fmem[xfer_idx]);
            xfer_idx++;
`ifdef FIFO_RD_STREAM_CNT_EN
            cnt_model = cnt_model + 32'd1;
`endif
        end
        p_hold = s_v && !rdy && !i_rst;
        p_d    = s_d;
        @(negedge i_clk);
    endtask

    initial begin
        int first_re, first_v, last_v, nv, pops0;
        i_rst     = 1'b1;
        i_m_ready = 1'b0;
        p_hold    = 1'b0;
        p_d       = '0;
`ifdef FIFO_RD_STREAM_CNT_EN
        cnt_model = 32'd0;
`endif
        tbl[0] = '{1'b1, 1'b0, 1'b0, 64'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 64'd0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 64'd0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 64'd0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 64'd0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 64'd0};

        // Reset table: FIFO holds one word so the pop gating is exercised.
        push(64'h77);
        @(negedge i_clk);
        for (int i = 0; i < 6; i++) begin
            i_rst     = tbl[i].rst;
            i_m_ready = 1'b1;
            #1;
            check("tbl_rd_en", {63'd0, o_fifo_rd_en}, {63'd0, tbl[i].exp_re});
            check("tbl_valid", {63'd0, o_m_valid}, {63'd0, tbl[i].exp_v});
            check("tbl_data", o_m_data, tbl[i].exp_d);
            @(negedge i_clk);
        end
        set_reset(1'b1);
        @(negedge i_clk);
        set_reset(1'b0);

        // Streaming 0x1..0x10 with ready held high.
        for (int w = 1; w <= 16; w++) push(w);
        pops0 = rd_idx;
        first_re = -1; first_v = -1; last_v = -1; nv = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1);
            if (s_re && first_re < 0) first_re = i;
            if (s_v && first_v < 0) first_v = i;
            if (s_v) begin
                last_v = i;
                nv++;
            end
        end
        check("stream_latency", first_v - first_re, 2);
        check("stream_words", nv, 16);
        check("stream_back_to_back", last_v - first_v, 15);
        check("stream_pops", rd_idx - pops0, 16);

        // Backpressure: only two words may be pulled while ready is low.
        push(64'hA); push(64'hB); push(64'hC);
        pops0 = rd_idx;
        for (int i = 0; i < 8; i++) step(1'b0);
        check("bp_pops", rd_idx - pops0, 2);
        check("bp_valid", {63'd0, s_v}, 64'd1);
        check("bp_head", s_d, 64'hA);
        for (int i = 0; i < 20 && xfer_idx < wr_idx; i++) step(1'b1);
        check("bp_drained", xfer_idx, wr_idx);

        // Empty FIFO for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            step(1'b1);
            check("empty_rd_en", {63'd0, s_re}, 64'd0);
            check("empty_valid", {63'd0, s_v}, 64'd0);
        end

        // Reset one cycle after popping 0x55: the word must be discarded.
        push(64'h55);
        step(1'b1);
        check("mid_pop_issued", {63'd0, s_re}, 64'd1);
        set_reset(1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            check("mid_rst_rd_en", {63'd0, s_re}, 64'd0);
            check("mid_rst_valid", {63'd0, s_v}, 64'd0);
            check("mid_rst_data", s_d, 64'd0);
        end
        set_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            check("mid_post_valid", {63'd0, s_v}, 64'd0);
        end
        push(64'h66);
        for (int i = 0; i < 6 && xfer_idx < wr_idx; i++) step(1'b1);
        check("mid_new_word", xfer_idx, wr_idx);

`ifdef FIFO_RD_STREAM_CNT_EN
        set_reset(1'b1);
        @(negedge i_clk);
        set_reset(1'b0);
        for (int w = 0; w < 5; w++) push(64'h100 + w);
        for (int i = 0; i < 12 && xfer_idx < wr_idx; i++) step(1'b1);
        check("cnt_five", {32'd0, o_word_cnt}, 64'd5);
        force dut.o_word_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.o_word_cnt;
        cnt_model = 32'hFFFF_FFFF;
        push(64'h200);
        for (int i = 0; i < 6 && xfer_idx < wr_idx; i++) step(1'b1);
        step(1'b1);
        check("cnt_wrap", {32'd0, o_word_cnt}, 64'd0);
`endif

        // Randomized traffic, then a bounded drain.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 45) push({$urandom, $urandom});
            if ($urandom_range(0, 99) < 10) push({$urandom, $urandom});
            step($urandom_range(0, 99) < 70);
        end
        for (int i = 0; i < 4000 && xfer_idx < wr_idx; i++) step(1'b1);
        check("random_all_delivered", xfer_idx, wr_idx);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of FIFO read data and stream data.
REQ-002 SHALL have port i_clk  input  1  sole clock, the FIFO read-side clock; all logic rising-edge.
REQ-003 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_fifo_empty  input  1  FIFO empty flag, synchronous to i_clk.
REQ-005 SHALL have port o_fifo_rd_en  output  1  FIFO pop request.
REQ-006 SHALL have port i_fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid the cycle after an accepted pop.
REQ-007 SHALL have port o_m_valid  output  1  stream word available.
REQ-008 SHALL have port i_m_ready  input  1  downstream accepts word.
REQ-009 SHALL have port o_m_data  output  DATA_WIDTH  stream word, head of buffer.

Function
REQ-010 SHALL define accepted pop as o_fifo_rd_en=1 at a rising edge; returned data SHALL be captured from i_fifo_rd_data at the next rising edge.
REQ-011 SHALL hold a 2-entry buffer, occupancy cnt in {0,1,2}, plus in-flight flag inf (pop issued, data not yet captured).
REQ-012 SHALL assert o_fifo_rd_en = !i_fifo_empty && ((cnt+inf)<2 || (o_m_valid && i_m_ready)).
REQ-013 SHALL maintain invariant cnt+inf <= 2 at every edge; buffer SHALL never overflow.
REQ-014 SHALL drive o_m_valid = (cnt != 0) and o_m_data = oldest buffered word; no combinational path from i_fifo_rd_data to o_m_data.
REQ-015 SHALL transfer a word when o_m_valid && i_m_ready, removing the head at that edge.
REQ-016 SHALL, on simultaneous capture and transfer, keep cnt unchanged and preserve order: new word placed behind remaining entry.
REQ-017 SHALL hold o_m_data and o_m_valid stable while o_m_valid=1 and i_m_ready=0.
REQ-018 SHALL never assert o_fifo_rd_en while i_fifo_empty=1 (no underflow pop).
REQ-019 SHALL sustain one word per cycle when FIFO non-empty and i_m_ready held 1; latency first pop to o_m_valid = 2 cycles.
REQ-020 SHALL deliver every popped word exactly once, in pop order, with no duplication or loss.

Reset
REQ-021 SHALL, on i_rst=1, asynchronously clear cnt, inf and all buffer pointers; o_m_valid=0, o_fifo_rd_en=0, o_m_data=0.
REQ-022 SHALL discard any in-flight word when reset asserts mid-operation; first capture after release only follows a post-reset pop.
REQ-023 SHALL hold o_fifo_rd_en=0 for the whole reset assertion, regardless of i_fifo_empty.

Configuration
REQ-024 SHALL honour macro FIFO_RD_STREAM_CNT_EN.
REQ-025 SHALL, with FIFO_RD_STREAM_CNT_EN defined, add port o_word_cnt output 32: count of stream transfers since reset, reset 0, +1 per transfer, wraps 0xFFFFFFFF->0.
REQ-026 SHALL, without FIFO_RD_STREAM_CNT_EN, omit o_word_cnt and its counter entirely; all other behaviour identical.

Verification
REQ-027 Reset: i_rst=1 with i_fifo_empty=0 -> o_fifo_rd_en=0, o_m_valid=0, o_m_data=0 throughout.
REQ-028 Streaming: FIFO model preloaded 0x1..0x10, i_m_ready=1 -> 16 words 0x1..0x10 in order, one per cycle after 2-cycle latency, 16 pops total.
REQ-029 Backpressure: FIFO holds 0xA,0xB,0xC, i_m_ready=0 -> exactly 2 pops, o_m_data=0xA stable; ready=1 -> 0xA,0xB,0xC delivered in order.
REQ-030 Empty: i_fifo_empty=1 for 20 cycles, i_m_ready=1 -> o_fifo_rd_en never 1, o_m_valid stays 0.
REQ-031 Mid-reset: assert i_rst one cycle after a pop of 0x55 -> 0x55 never appears on stream; o_m_valid=0 until new pop completes.
REQ-032 Counter (macro defined): 5 transfers after reset -> o_word_cnt=5; forced to 0xFFFFFFFF plus 1 transfer -> 0.
